// File: rtl/mux2_rr_feeder_pkg.sv
// Shared types and defaults for the mux2_rr_feeder arbiter slice.
package mux2_rr_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_MAX_HOLD = 4;

endpackage

// File: rtl/mux2_rr_feeder_grant_hold_counter.sv
// Burst-length counter for the current grant: clear on grant change,
// count accepted transfers, saturate at MAX_HOLD.
module grant_hold_counter
  import mux2_rr_feeder_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hold_done
);

  logic [7:0] cnt_r;

  // Counter register with clear priority over increment and saturation at MAX_HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 8'd0;
    end else if (clr) begin
      cnt_r <= 8'd0;
    end else if (inc && (cnt_r < 8'(MAX_HOLD))) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // High when the next accepted transfer completes (or has already completed) the burst.
  assign hold_done = (cnt_r >= 8'(MAX_HOLD - 1));

endmodule

// File: rtl/mux2_rr_feeder.sv
// Round-robin two-channel feeder with bounded burst and registered mux select.
// Optional macro MUX2RR_PARITY_EN adds the registered out_par output.
module mux2_rr_feeder
  import mux2_rr_feeder_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  output logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef MUX2RR_PARITY_EN
  output logic             out_par,
`endif
  output logic             out_src
);

`ifdef MUX2RR_PARITY_EN
  function automatic logic even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  state_t state_r;
  state_t state_nxt_s;
  logic   last_r;
  logic   bubble_r;
  logic   hold_switch_s;
  logic   hold_done_s;
  logic   slot_free_s;
  logic   xfer0_s;
  logic   xfer1_s;

  // A hold-driven switch coincides with a transfer; bubble_r gives the new select one idle cycle.
  assign slot_free_s = !out_valid || out_ready;
  assign in0_ready   = (state_r == ST_G0) && !bubble_r && slot_free_s;
  assign in1_ready   = (state_r == ST_G1) && !bubble_r && slot_free_s;
  assign xfer0_s     = in0_valid && in0_ready;
  assign xfer1_s     = in1_valid && in1_ready;

  grant_hold_counter #(.MAX_HOLD(MAX_HOLD)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_nxt_s != state_r),
    .inc       (xfer0_s || xfer1_s),
    .hold_done (hold_done_s)
  );

  // Next grant: idle arbitration, valid-drop handoff and burst-limit handoff.
  always_comb begin
    state_nxt_s   = state_r;
    hold_switch_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in0_valid && in1_valid) begin
          state_nxt_s = last_r ? ST_G0 : ST_G1;
        end else if (in0_valid) begin
          state_nxt_s = ST_G0;
        end else if (in1_valid) begin
          state_nxt_s = ST_G1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_G0: begin
        if (!in0_valid) begin
          state_nxt_s = in1_valid ? ST_G1 : ST_IDLE;
        end else if (xfer0_s && hold_done_s && in1_valid) begin
          state_nxt_s   = ST_G1;
          hold_switch_s = 1'b1;
        end else begin
          state_nxt_s = ST_G0;
        end
      end
      ST_G1: begin
        if (!in1_valid) begin
          state_nxt_s = in0_valid ? ST_G0 : ST_IDLE;
        end else if (xfer1_s && hold_done_s && in0_valid) begin
          state_nxt_s   = ST_G0;
          hold_switch_s = 1'b1;
        end else begin
          state_nxt_s = ST_G1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Grant state, last-served channel and registered mux select.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      sel      <= 1'b0;
      last_r   <= 1'b1;
      bubble_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      bubble_r <= hold_switch_s;
      if (state_nxt_s != state_r) begin
        if (state_r == ST_G0) begin
          last_r <= 1'b0;
        end else if (state_r == ST_G1) begin
          last_r <= 1'b1;
        end else begin
          last_r <= last_r;
        end
        if (state_nxt_s == ST_G0) begin
          sel <= 1'b0;
        end else if (state_nxt_s == ST_G1) begin
          sel <= 1'b1;
        end else begin
          sel <= sel;
        end
      end
    end
  end

  // Output register: capture on transfer, otherwise drain when downstream accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
`ifdef MUX2RR_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else if (xfer0_s || xfer1_s) begin
      out_valid <= 1'b1;
      out_data  <= xfer1_s ? in1_data : in0_data;
      out_src   <= xfer1_s;
`ifdef MUX2RR_PARITY_EN
      out_par   <= even_par(xfer1_s ? in1_data : in0_data);
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_mux2_rr_feeder.sv
// Self-checking bench for mux2_rr_feeder: vector table plus scoreboarded corner sequences.
module tb_mux2_rr_feeder;
  import mux2_rr_feeder_pkg::*;

  logic       clk;
  logic       rst;
  logic       in0_valid, in1_valid, out_ready;
  logic       in0_ready, in1_ready;
  logic [7:0] in0_data, in1_data, out_data;
  logic       sel, out_valid, out_src;
`ifdef MUX2RR_PARITY_EN
  logic       out_par;
`endif

  mux2_rr_feeder #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef MUX2RR_PARITY_EN
    .out_par   (out_par),
`endif
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q[$];
  logic [7:0] d0 = 8'h00;
  logic [7:0] d1 = 8'h00;

  typedef struct {
    logic r, v0, v1, ordy;
    logic eov, esrc, esel;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive, score the handshakes about to happen, then check after the edge.
  task automatic step(input logic r, input logic v0, input logic v1, input logic ordy);
    logic       pushed;
    logic [8:0] pv;
    rst = r; in0_valid = v0; in1_valid = v1; out_ready = ordy;
    in0_data = d0; in1_data = d1;
    pushed = 1'b0; pv = 9'd0;
    #1;
    if (!r) begin
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("sb_word", 32'({out_src, out_data}), 32'(exp_q.pop_front()));
      end
      if (in0_valid && in0_ready === 1'b1) begin
        pv = {1'b0, d0}; pushed = 1'b1; exp_q.push_back(pv); d0 = d0 + 8'd1;
      end else if (in1_valid && in1_ready === 1'b1) begin
        pv = {1'b1, d1}; pushed = 1'b1; exp_q.push_back(pv); d1 = d1 + 8'd1;
      end
    end else begin
      exp_q.delete();
    end
    @(posedge clk); #1;
    if (pushed) begin
      chk("latency_valid", 32'(out_valid), 32'd1);
      chk("latency_word", 32'({out_src, out_data}), 32'(pv));
    end
`ifdef MUX2RR_PARITY_EN
    if (out_valid) chk("parity", 32'(out_par), 32'(^out_data));
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    in0_data = 8'h00; in1_data = 8'h00;

    // Reset with both valids high, then both channels always valid: 4/bubble/4/bubble.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    d0 = 8'hA0; d1 = 8'hB0;
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].v0, tbl[i].v1, tbl[i].ordy);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].eov));
      if (tbl[i].eov) chk($sformatf("tbl%0d_src", i), 32'(out_src), 32'(tbl[i].esrc));
      chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].esel));
      if (tbl[i].r) begin
        chk("rst_in0_ready", 32'(in0_ready), 32'd0);
        chk("rst_in1_ready", 32'(in1_ready), 32'd0);
      end
      if (i == 2) chk("first_grant_g0", 32'(dut.state_r), 32'(ST_G0));
    end
    drain();

    // Single channel stream 0x11..0x16; counter saturates at MAX_HOLD.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    d0 = 8'h11;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, (d0 <= 8'h16), 1'b0, 1'b1);
      chk("single_sel", 32'(sel), 32'd0);
      if (i == 6) chk("single_sat", 32'(dut.u_hold.cnt_r), 32'd4);
    end
    chk("single_count", 32'(d0), 32'h17);
    drain();

    // Backpressure: five cycles of out_ready low mid-stream.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    d0 = 8'h30;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("bp_in0_ready", 32'(in0_ready), 32'd0);
      chk("bp_in1_ready", 32'(in1_ready), 32'd0);
      chk("bp_hold_data", 32'(out_data), 32'h31);
      chk("bp_hold_cnt", 32'(dut.u_hold.cnt_r), 32'd2);
    end
    for (int i = 0; i < 8; i++) step(1'b0, (d0 <= 8'h35), 1'b0, 1'b1);
    chk("bp_count", 32'(d0), 32'h36);
    drain();

    // Valid drop on ch1 while ch0 waits: handoff on the next edge.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    d1 = 8'h50;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("drop_sel_before", 32'(sel), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("drop_sel", 32'(sel), 32'd0);
    chk("drop_state", 32'(dut.state_r), 32'(ST_G0));
    chk("drop_cnt", 32'(dut.u_hold.cnt_r), 32'd0);
    drain();

    // Reset in the middle of a ch1 burst drops the held word.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    d1 = 8'h05;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("mid_sel_before", 32'(sel), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_state", 32'(dut.state_r), 32'(ST_IDLE));
    chk("mid_rst_sel", 32'(sel), 32'd0);
    d0 = 8'h07;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("word07", 32'(out_data), 32'h07);
`ifdef MUX2RR_PARITY_EN
    chk("par07", 32'(out_par), 32'd1);
`endif
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
